// File: rtl/ipf_seq_driver.sv
// Job sequencer for the IPF multiply engine: accepts one command, streams weight rows,
// then per-round/per-group input passes, an optional padding tail, a drain, and an END cycle.
module ipf_seq_driver #(
    parameter int DW        = 64,
    parameter int DRAIN_CYC = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_wsize,
    input  logic          cmd_stride,
    input  logic          cmd_groups,
    input  logic          cmd_pad,
    output logic [4:0]    w_rd_addr,
    input  logic [DW-1:0] w_rd_data,
    output logic [2:0]    i_rd_addr,
    input  logic [DW-1:0] i_rd_data,
    output logic          w_valid,
    output logic [DW-1:0] w_data,
    output logic          i_valid,
    output logic [DW-1:0] i_data,
    output logic [1:0]    ctrl,
    output logic [1:0]    Wsize,
    output logic          stride,
    output logic [3:0]    wgroup,
    output logic [2:0]    wround,
    output logic [1:0]    RLPadding,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int CW = (DRAIN_CYC > 31) ? $clog2(DRAIN_CYC) : 5;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOADW, S_PASS, S_PADT, S_DRAIN, S_END
    } state_t;

    state_t        r_state, w_nxt_state;
    logic [CW-1:0] r_cnt, w_nxt_cnt;
    logic [1:0]    r_round, w_nxt_round;
    logic          r_grp, w_nxt_grp;

    logic [1:0]    r_wsize;
    logic          r_stride, r_groups, r_pad, r_illegal;

    logic          r_ready, r_busy, r_done, r_err, r_w_valid, r_i_valid;
    logic [1:0]    r_ctrl, r_rlpad;
    logic [2:0]    r_wround;
    logic          r_wgroup;
    logic [4:0]    r_w_addr;
    logic [2:0]    r_i_addr;

    logic          w_ready, w_busy, w_done, w_err, w_wv, w_iv, w_wgroup;
    logic [1:0]    w_ctrl, w_rlpad;
    logic [2:0]    w_wround;
    logic [4:0]    w_waddr;
    logic [2:0]    w_iaddr;

    // Per-job constants derived from the latched command
    logic [CW-1:0] w_nw;
    logic [2:0]    w_pre;
    logic [1:0]    w_last_round;
    logic          w_last_grp;

    always_comb begin
        w_nw         = (r_wsize == 2'd0) ? CW'(18) : CW'(25);
        w_pre        = r_pad ? 3'd0 : (r_wsize == 2'd0) ? 3'd2 : (r_wsize == 2'd1) ? 3'd4 : 3'd6;
        w_last_round = r_pad ? 2'd0 : (r_wsize == 2'd0) ? 2'd0 : (r_wsize == 2'd1) ? 2'd1 : 2'd3;
        w_last_grp   = !r_pad && !r_stride && r_groups;
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_round = r_round;
        w_nxt_grp   = r_grp;
        case (r_state)
            S_IDLE:  if (cmd_valid) w_nxt_state = S_FETCH;
            S_FETCH: begin
                w_nxt_cnt   = '0;
                w_nxt_state = r_illegal ? S_END : S_LOADW;
            end
            S_LOADW: begin
                if (r_cnt == w_nw - CW'(1)) begin
                    w_nxt_state = S_PASS;
                    w_nxt_cnt   = '0;
                    w_nxt_round = '0;
                    w_nxt_grp   = 1'b0;
                end else begin
                    w_nxt_cnt = r_cnt + CW'(1);
                end
            end
            S_PASS: begin
                if (r_cnt == CW'(7)) begin
                    w_nxt_cnt = '0;
                    if (r_grp != w_last_grp) begin
                        w_nxt_grp = 1'b1;
                    end else if (r_round != w_last_round) begin
                        w_nxt_round = r_round + 2'd1;
                        w_nxt_grp   = 1'b0;
                    end else begin
                        w_nxt_state = r_pad ? S_PADT : S_DRAIN;
                    end
                end else begin
                    w_nxt_cnt = r_cnt + CW'(1);
                end
            end
            S_PADT: begin
                if (r_cnt == CW'(1)) begin
                    w_nxt_state = S_DRAIN;
                    w_nxt_cnt   = '0;
                end else begin
                    w_nxt_cnt = r_cnt + CW'(1);
                end
            end
            S_DRAIN: begin
                if (r_cnt == CW'(DRAIN_CYC - 1)) w_nxt_state = S_END;
                else                             w_nxt_cnt   = r_cnt + CW'(1);
            end
            S_END:   w_nxt_state = S_IDLE;
            default: w_nxt_state = S_IDLE;
        endcase
    end

    // Outputs are computed for the state being entered, so every output is a flop
    always_comb begin
        w_ready  = (w_nxt_state == S_IDLE);
        w_busy   = (w_nxt_state != S_IDLE);
        w_done   = (w_nxt_state == S_END);
        w_err    = (w_nxt_state == S_END) && r_illegal;
        w_wv     = (w_nxt_state == S_LOADW);
        w_iv     = (w_nxt_state == S_PASS);
        w_rlpad  = (w_nxt_state == S_PADT) ? 2'd2 : 2'd0;
        w_ctrl   = 2'd2;
        w_wround = r_wround;
        w_wgroup = r_wgroup;
        w_waddr  = 5'd0;
        w_iaddr  = 3'd0;
        case (w_nxt_state)
            S_IDLE: begin
                w_wround = 3'd0;
                w_wgroup = 1'b0;
            end
            S_LOADW: begin
                if (w_nxt_cnt != w_nw - CW'(1)) w_waddr = 5'(w_nxt_cnt + CW'(1));
            end
            S_PASS: begin
                w_iaddr = w_nxt_cnt[2:0] + 3'd1;
                if (w_nxt_cnt >= CW'(w_pre)) begin
                    w_ctrl   = 2'd1;
                    w_wround = {1'b0, w_nxt_round};
                end
                if (!r_stride)                     w_wgroup = w_nxt_grp;
                else if (w_nxt_cnt == CW'(w_pre))  w_wgroup = 1'b0;
                else if (w_nxt_cnt > CW'(w_pre))   w_wgroup = ~r_wgroup;
            end
            S_PADT:  w_ctrl = 2'd1;
            S_END:   w_ctrl = 2'd0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_round   <= '0;
            r_grp     <= 1'b0;
            r_wsize   <= '0;
            r_stride  <= 1'b0;
            r_groups  <= 1'b0;
            r_pad     <= 1'b0;
            r_illegal <= 1'b0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_w_valid <= 1'b0;
            r_i_valid <= 1'b0;
            r_ctrl    <= 2'd2;
            r_rlpad   <= '0;
            r_wround  <= '0;
            r_wgroup  <= 1'b0;
            r_w_addr  <= '0;
            r_i_addr  <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_round <= w_nxt_round;
            r_grp   <= w_nxt_grp;
            if (r_state == S_IDLE && cmd_valid) begin
                r_wsize   <= cmd_wsize;
                r_stride  <= cmd_stride;
                r_groups  <= cmd_groups;
                r_pad     <= cmd_pad;
                r_illegal <= (cmd_wsize == 2'd3) || (cmd_pad && cmd_wsize != 2'd0);
            end
            r_ready   <= w_ready;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_err     <= w_err;
            r_w_valid <= w_wv;
            r_i_valid <= w_iv;
            r_ctrl    <= w_ctrl;
            r_rlpad   <= w_rlpad;
            r_wround  <= w_wround;
            r_wgroup  <= w_wgroup;
            r_w_addr  <= w_waddr;
            r_i_addr  <= w_iaddr;
        end
    end

    // Row buffers register their read data, so the beat data is their output gated by valid
    assign w_data    = r_w_valid ? w_rd_data : '0;
    assign i_data    = r_i_valid ? i_rd_data : '0;
    assign cmd_ready = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign w_valid   = r_w_valid;
    assign i_valid   = r_i_valid;
    assign ctrl      = r_ctrl;
    assign RLPadding = r_rlpad;
    assign wround    = r_wround;
    assign wgroup    = {3'b000, r_wgroup};
    assign w_rd_addr = r_w_addr;
    assign i_rd_addr = r_i_addr;
    assign Wsize     = r_wsize;
    assign stride    = r_stride;

endmodule

// File: tb/tb_ipf_seq_driver.sv
// Bench for ipf_seq_driver: row-buffer models plus a per-cycle expected trace built from job rules.
module tb_ipf_seq_driver;
    localparam int DW        = 64;
    localparam int DRAIN_CYC = 10;

    logic          clk, rst, cmd_valid, cmd_ready, cmd_stride, cmd_groups, cmd_pad;
    logic [1:0]    cmd_wsize;
    logic [4:0]    w_rd_addr;
    logic [2:0]    i_rd_addr;
    logic [DW-1:0] w_rd_data, i_rd_data, w_data, i_data;
    logic          w_valid, i_valid, stride, busy, done, err;
    logic [1:0]    ctrl, Wsize, RLPadding;
    logic [3:0]    wgroup;
    logic [2:0]    wround;

    ipf_seq_driver #(.DW(DW), .DRAIN_CYC(DRAIN_CYC)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_wsize(cmd_wsize), .cmd_stride(cmd_stride), .cmd_groups(cmd_groups), .cmd_pad(cmd_pad),
        .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data), .i_rd_addr(i_rd_addr), .i_rd_data(i_rd_data),
        .w_valid(w_valid), .w_data(w_data), .i_valid(i_valid), .i_data(i_data),
        .ctrl(ctrl), .Wsize(Wsize), .stride(stride), .wgroup(wgroup), .wround(wround),
        .RLPadding(RLPadding), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] wmem [32];
    logic [DW-1:0] imem [8];

    always @(posedge clk) begin
        w_rd_data <= wmem[w_rd_addr];
        i_rd_data <= imem[i_rd_addr];
    end

    typedef struct packed {
        logic          rdy, bsy, dn, er;
        logic [1:0]    ct, ws;
        logic          st;
        logic [3:0]    wg;
        logic [2:0]    wr;
        logic [1:0]    rl;
        logic          wv;
        logic [DW-1:0] wd;
        logic          iv;
        logic [DW-1:0] id;
    } obs_t;

    obs_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    function automatic obs_t sample();
        obs_t o;
        o = '{rdy: cmd_ready, bsy: busy, dn: done, er: err, ct: ctrl, ws: Wsize, st: stride,
              wg: wgroup, wr: wround, rl: RLPadding, wv: w_valid, wd: w_data, iv: i_valid, id: i_data};
        return o;
    endfunction

    function automatic obs_t idle_rec(input logic [1:0] ws, input logic st);
        obs_t e;
        e = '0;
        e.rdy = 1'b1;
        e.ct  = 2'd2;
        e.ws  = ws;
        e.st  = st;
        return e;
    endfunction

    task automatic check_obs(input string tag, input obs_t exp);
        obs_t o;
        o = sample();
        n_chk++;
        assert (o === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, o, exp);
    endtask

    // Expected trace from the cycle after accept through the first idle cycle after END
    function automatic void build(input logic [1:0] ws, input logic st, input logic gp, input logic pd);
        obs_t e, base;
        logic legal;
        int nw, p, r_n, g_n;
        logic [2:0] wr;
        logic wg;
        legal = (ws != 2'd3) && !(pd && ws != 2'd0);
        nw  = (ws == 2'd0) ? 18 : 25;
        p   = pd ? 0 : (ws == 2'd0) ? 2 : (ws == 2'd1) ? 4 : 6;
        r_n = pd ? 1 : (ws == 2'd0) ? 1 : (ws == 2'd1) ? 2 : 4;
        g_n = (pd || st) ? 1 : (gp ? 2 : 1);
        wr  = 3'd0;
        wg  = 1'b0;
        base = '0;
        base.bsy = 1'b1;
        base.ct  = 2'd2;
        base.ws  = ws;
        base.st  = st;
        exp_q.push_back(base);
        if (legal) begin
            for (int k = 0; k < nw; k++) begin
                e = base; e.wv = 1'b1; e.wd = wmem[k];
                exp_q.push_back(e);
            end
            for (int r = 0; r < r_n; r++)
                for (int g = 0; g < g_n; g++)
                    for (int b = 0; b < 8; b++) begin
                        e = base; e.iv = 1'b1; e.id = imem[b];
                        if (b >= p) begin
                            e.ct = 2'd1;
                            wr   = 3'(r);
                        end
                        if (!st)         wg = 1'(g);
                        else if (b >= p) wg = 1'((b - p) % 2);
                        e.wr = wr; e.wg = {3'b000, wg};
                        exp_q.push_back(e);
                    end
            if (pd)
                for (int k = 0; k < 2; k++) begin
                    e = base; e.ct = 2'd1; e.rl = 2'd2; e.wr = wr; e.wg = {3'b000, wg};
                    exp_q.push_back(e);
                end
            for (int k = 0; k < DRAIN_CYC; k++) begin
                e = base; e.wr = wr; e.wg = {3'b000, wg};
                exp_q.push_back(e);
            end
        end
        e = base; e.ct = 2'd0; e.dn = 1'b1; e.er = !legal; e.wr = wr; e.wg = {3'b000, wg};
        exp_q.push_back(e);
        exp_q.push_back(idle_rec(ws, st));
    endfunction

    // Runs one job from an idle negedge; junk commands are offered while busy and must be ignored
    task automatic run_job(input logic [1:0] ws, input logic st, input logic gp, input logic pd,
                           input string tag);
        obs_t e;
        exp_q.delete();
        build(ws, st, gp, pd);
        cmd_valid = 1'b1; cmd_wsize = ws; cmd_stride = st; cmd_groups = gp; cmd_pad = pd;
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_obs(tag, e);
            if (e.rdy) cmd_valid = 1'b0;
            else begin
                cmd_valid  = 1'($urandom);
                cmd_wsize  = 2'($urandom);
                cmd_stride = 1'($urandom);
                cmd_groups = 1'($urandom);
                cmd_pad    = 1'($urandom);
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        for (int k = 0; k < 32; k++) wmem[k] = {$urandom, $urandom};
        for (int k = 0; k < 8; k++)  imem[k] = {$urandom, $urandom};
        rst = 1'b1; cmd_valid = 1'b0; cmd_wsize = '0; cmd_stride = 1'b0; cmd_groups = 1'b0; cmd_pad = 1'b0;
        repeat (2) @(negedge clk);
        check_obs("reset", idle_rec(2'd0, 1'b0));
        n_chk++;
        assert (w_rd_addr === 5'd0 && i_rd_addr === 3'd0) n_pass++;
        else $error("FAIL reset_addr: observed %0d/%0d expected 0/0", w_rd_addr, i_rd_addr);
        rst = 1'b0;
        @(negedge clk);

        run_job(2'd0, 1'b0, 1'b1, 1'b0, "3x3_s1_g2");
        run_job(2'd0, 1'b1, 1'b0, 1'b0, "3x3_s2");
        run_job(2'd1, 1'b0, 1'b0, 1'b0, "5x5_s1");
        run_job(2'd2, 1'b0, 1'b0, 1'b0, "7x7_s1");
        run_job(2'd2, 1'b0, 1'b1, 1'b0, "7x7_s1_g2");
        run_job(2'd1, 1'b1, 1'b1, 1'b0, "5x5_s2_grp_ignored");
        run_job(2'd0, 1'b0, 1'b0, 1'b1, "pad_3x3");
        run_job(2'd0, 1'b1, 1'b1, 1'b1, "pad_3x3_s2");
        run_job(2'd3, 1'b0, 1'b0, 1'b0, "illegal_wsize3");
        run_job(2'd1, 1'b0, 1'b0, 1'b1, "illegal_pad_5x5");

        // Abort mid-pass: the cycle after rst must be plain idle with no END emitted
        cmd_valid = 1'b1; cmd_wsize = 2'd0; cmd_stride = 1'b0; cmd_groups = 1'b1; cmd_pad = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (i_valid === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        repeat (3) @(negedge clk);
        n_chk++;
        assert (seen && i_valid === 1'b1) n_pass++;
        else $error("FAIL rst_reach_pass: observed i_valid %b expected 1", i_valid);
        rst = 1'b1;
        @(negedge clk);
        check_obs("rst_mid_pass", idle_rec(2'd0, 1'b0));
        rst = 1'b0;
        @(negedge clk);
        check_obs("after_abort_idle", idle_rec(2'd0, 1'b0));

        for (int j = 0; j < 10; j++) begin
            for (int k = 0; k < 8; k++) imem[k] = {$urandom, $urandom};
            run_job(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
